// File: rtl/ram16_arbiter.sv
// Round-robin arbiter sharing one ram16 (word-wide, byte-addressed, registered read)
// between requester A (fetch) and requester B (load/store). All outputs registered.
module ram16_arbiter #(
  parameter int unsigned addrSize = 9
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                a_req,
  input  logic                a_write,
  input  logic [addrSize-1:0] a_addr,
  input  logic [15:0]         a_wdata,
  output logic                a_ack,
  output logic [15:0]         a_rdata,
  output logic                a_err,
  input  logic                b_req,
  input  logic                b_write,
  input  logic [addrSize-1:0] b_addr,
  input  logic [15:0]         b_wdata,
  output logic                b_ack,
  output logic [15:0]         b_rdata,
  output logic                b_err,
  output logic [addrSize-1:0] ram_addr,
  output logic [15:0]         ram_data_in,
  output logic                ram_write_rq,
  output logic                ram_output_en,
  input  logic [15:0]         ram_data_out
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  state_e              state_q, state_d;
  logic                prio_q, prio_d;       // 0 = A has priority, 1 = B
  logic                gnt_q, gnt_d;         // 0 = A granted, 1 = B granted
  logic                wr_q, wr_d;
  logic                err_pend_q, err_pend_d;
  logic [addrSize-1:0] ram_addr_q, ram_addr_d;
  logic [15:0]         ram_data_in_q, ram_data_in_d;
  logic                ram_write_rq_q, ram_write_rq_d;
  logic                ram_output_en_q, ram_output_en_d;
  logic                a_ack_q, a_ack_d, b_ack_q, b_ack_d;
  logic                a_err_q, a_err_d, b_err_q, b_err_d;
  logic [15:0]         a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;

  logic                any_req, sel_b, sel_write, sel_top;
  logic [addrSize-1:0] sel_addr;
  logic [15:0]         sel_wdata;

  always_comb begin
    any_req   = a_req | b_req;
    sel_b     = b_req & (~a_req | prio_q);
    sel_write = sel_b ? b_write : a_write;
    sel_addr  = sel_b ? b_addr  : a_addr;
    sel_wdata = sel_b ? b_wdata : a_wdata;
    // The high byte lives at addr+1, so the last byte address cannot hold a word.
    sel_top   = (sel_addr == '1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      prio_q          <= 1'b0;
      gnt_q           <= 1'b0;
      wr_q            <= 1'b0;
      err_pend_q      <= 1'b0;
      ram_addr_q      <= '0;
      ram_data_in_q   <= '0;
      ram_write_rq_q  <= 1'b0;
      ram_output_en_q <= 1'b0;
      a_ack_q         <= 1'b0;
      b_ack_q         <= 1'b0;
      a_err_q         <= 1'b0;
      b_err_q         <= 1'b0;
      a_rdata_q       <= '0;
      b_rdata_q       <= '0;
    end else begin
      state_q         <= state_d;
      prio_q          <= prio_d;
      gnt_q           <= gnt_d;
      wr_q            <= wr_d;
      err_pend_q      <= err_pend_d;
      ram_addr_q      <= ram_addr_d;
      ram_data_in_q   <= ram_data_in_d;
      ram_write_rq_q  <= ram_write_rq_d;
      ram_output_en_q <= ram_output_en_d;
      a_ack_q         <= a_ack_d;
      b_ack_q         <= b_ack_d;
      a_err_q         <= a_err_d;
      b_err_q         <= b_err_d;
      a_rdata_q       <= a_rdata_d;
      b_rdata_q       <= b_rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req) state_d = sel_top ? DONE : ACCESS;
      ACCESS:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    prio_d          = prio_q;
    gnt_d           = gnt_q;
    wr_d            = wr_q;
    err_pend_d      = err_pend_q;
    ram_addr_d      = ram_addr_q;
    ram_data_in_d   = ram_data_in_q;
    ram_write_rq_d  = 1'b0;
    ram_output_en_d = 1'b0;
    a_ack_d         = 1'b0;
    b_ack_d         = 1'b0;
    a_err_d         = 1'b0;
    b_err_d         = 1'b0;
    a_rdata_d       = a_rdata_q;
    b_rdata_d       = b_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          gnt_d           = sel_b;
          wr_d            = sel_write;
          err_pend_d      = sel_top;
          ram_addr_d      = sel_addr;
          ram_data_in_d   = sel_wdata;
          ram_write_rq_d  = ~sel_top & sel_write;
          ram_output_en_d = ~sel_top & ~sel_write;
        end
      end
      DONE: begin
        // RAM data_out still carries the word registered on the ACCESS edge.
        if (gnt_q) begin
          b_ack_d   = 1'b1;
          b_err_d   = err_pend_q;
          b_rdata_d = (wr_q | err_pend_q) ? '0 : ram_data_out;
        end else begin
          a_ack_d   = 1'b1;
          a_err_d   = err_pend_q;
          a_rdata_d = (wr_q | err_pend_q) ? '0 : ram_data_out;
        end
        prio_d = ~gnt_q;
      end
      default: ;
    endcase
  end

  assign ram_addr      = ram_addr_q;
  assign ram_data_in   = ram_data_in_q;
  assign ram_write_rq  = ram_write_rq_q;
  assign ram_output_en = ram_output_en_q;
  assign a_ack         = a_ack_q;
  assign a_err         = a_err_q;
  assign a_rdata       = a_rdata_q;
  assign b_ack         = b_ack_q;
  assign b_err         = b_err_q;
  assign b_rdata       = b_rdata_q;

endmodule

// File: tb/tb_ram16_arbiter.sv
// Directed bench for ram16_arbiter with a behavioural ram16 model attached.
module tb_ram16_arbiter;
  localparam int unsigned AW = 9;

  logic          clk = 1'b0;
  logic          reset;
  logic          a_req, a_write, b_req, b_write;
  logic [AW-1:0] a_addr, b_addr;
  logic [15:0]   a_wdata, b_wdata;
  logic          a_ack, a_err, b_ack, b_err;
  logic [15:0]   a_rdata, b_rdata;
  logic [AW-1:0] ram_addr;
  logic [15:0]   ram_data_in, ram_data_out;
  logic          ram_write_rq, ram_output_en;

  always #5 clk = ~clk;

  ram16_arbiter #(.addrSize(AW)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_write(a_write), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_write(b_write), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata), .b_err(b_err),
    .ram_addr(ram_addr), .ram_data_in(ram_data_in),
    .ram_write_rq(ram_write_rq), .ram_output_en(ram_output_en),
    .ram_data_out(ram_data_out)
  );

  // ram16 model: byte array, low byte at addr, high byte at addr+1, registered read.
  logic [7:0]    mem [0:(1<<AW)-1];
  logic [AW-1:0] ram_addr_p1;
  assign ram_addr_p1 = ram_addr + 1'b1;
  always @(posedge clk) begin
    if (ram_write_rq) begin
      mem[ram_addr]    <= ram_data_in[7:0];
      mem[ram_addr_p1] <= ram_data_in[15:8];
    end
    ram_data_out <= ram_output_en ? {mem[ram_addr_p1], mem[ram_addr]} : 16'h0000;
  end

  int            wr_pulses = 0, oe_pulses = 0;
  logic [AW-1:0] pulse_addr = '0;
  always @(posedge clk) begin
    if (ram_write_rq)  begin wr_pulses <= wr_pulses + 1; pulse_addr <= ram_addr; end
    if (ram_output_en) begin oe_pulses <= oe_pulses + 1; pulse_addr <= ram_addr; end
  end

  int n_vec = 0, n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit            sel;      // 0 = A, 1 = B
    bit            wr;
    logic [AW-1:0] addr;
    logic [15:0]   wdata;
    logic [15:0]   exp_rd;
    bit            exp_err;
  } vec_t;

  // Called at a negedge; returns at the negedge where the ack was seen, req dropped.
  task automatic run_access(input vec_t v, input string tag);
    int wr0, oe0, cyc;
    bit got;
    wr0 = wr_pulses; oe0 = oe_pulses;
    if (!v.sel) begin a_req = 1; a_write = v.wr; a_addr = v.addr; a_wdata = v.wdata; end
    else        begin b_req = 1; b_write = v.wr; b_addr = v.addr; b_wdata = v.wdata; end
    got = 0; cyc = 0;
    while (!got && cyc < 12) begin
      @(negedge clk);
      cyc++;
      got = v.sel ? b_ack : a_ack;
    end
    chk({tag, " ack"}, 32'(got), 1);
    if (got) begin
      chk({tag, " latency"}, cyc, v.exp_err ? 2 : 3);
      chk({tag, " rdata"}, v.sel ? b_rdata : a_rdata, v.exp_rd);
      chk({tag, " err"}, v.sel ? b_err : a_err, v.exp_err);
      chk({tag, " other ack"}, v.sel ? a_ack : b_ack, 0);
    end
    chk({tag, " wr pulses"}, wr_pulses - wr0, (v.wr && !v.exp_err) ? 1 : 0);
    chk({tag, " oe pulses"}, oe_pulses - oe0, (!v.wr && !v.exp_err) ? 1 : 0);
    if (!v.exp_err) chk({tag, " ram addr"}, 32'(pulse_addr), 32'(v.addr));
    a_req = 0; b_req = 0;
  endtask

  vec_t vecs[11];
  vec_t rd_a, rd_b;

  initial begin
    int  cyc;
    bit  got;
    vecs[0]  = '{1'b0, 1'b1, 9'h010, 16'hBEEF, 16'h0000, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 9'h010, 16'h0000, 16'hBEEF, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 9'h020, 16'h1234, 16'h0000, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 9'h1FF, 16'h5555, 16'h0000, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 9'h011, 16'hA55A, 16'h0000, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 9'h010, 16'h0000, 16'h5AEF, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 9'h020, 16'h0000, 16'h1234, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 9'h1FE, 16'hC0DE, 16'h0000, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 9'h1FE, 16'h0000, 16'hC0DE, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 9'h1FF, 16'h0000, 16'h0000, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 9'h1FF, 16'h0000, 16'h0000, 1'b1};
    rd_a = '{1'b0, 1'b0, 9'h010, 16'h0000, 16'h5AEF, 1'b0};
    rd_b = '{1'b1, 1'b0, 9'h020, 16'h0000, 16'h1234, 1'b0};

    a_req = 0; a_write = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_write = 0; b_addr = '0; b_wdata = '0;
    reset = 1;
    #2 reset = 0;
    repeat (2) @(negedge clk);
    chk("reset ack/err", {28'd0, a_ack, a_err, b_ack, b_err}, 0);
    chk("reset rdata", {a_rdata, b_rdata}, 0);
    chk("reset ram ctl", {30'd0, ram_write_rq, ram_output_en}, 0);
    chk("reset ram addr/data", {7'd0, ram_addr, ram_data_in}, 0);
    reset = 1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) run_access(vecs[i], $sformatf("vec%0d", i));

    // Both held: grants must alternate A, B, A, B (last table access was B).
    a_req = 1; a_write = 0; a_addr = rd_a.addr;
    b_req = 1; b_write = 0; b_addr = rd_b.addr;
    for (int k = 0; k < 4; k++) begin
      got = 0; cyc = 0;
      while (!got && cyc < 12) begin
        @(negedge clk);
        cyc++;
        got = a_ack | b_ack;
      end
      chk($sformatf("alt%0d ack seen", k), 32'(got), 1);
      chk($sformatf("alt%0d latency", k), cyc, 3);
      chk($sformatf("alt%0d a_ack", k), a_ack, (k % 2 == 0) ? 1 : 0);
      chk($sformatf("alt%0d b_ack", k), b_ack, (k % 2 == 0) ? 0 : 1);
      chk($sformatf("alt%0d rdata", k), (k % 2 == 0) ? a_rdata : b_rdata,
          (k % 2 == 0) ? rd_a.exp_rd : rd_b.exp_rd);
    end
    a_req = 0; b_req = 0;

    // A served alone moves priority to B, so the next contention grants B first.
    run_access(rd_a, "solo A");
    a_req = 1; a_write = 0; a_addr = rd_a.addr;
    b_req = 1; b_write = 0; b_addr = rd_b.addr;
    got = 0; cyc = 0;
    while (!got && cyc < 12) begin @(negedge clk); cyc++; got = a_ack | b_ack; end
    chk("contend first is B", {30'd0, a_ack, b_ack}, 2'b01);
    chk("contend B rdata", b_rdata, 16'h1234);
    b_req = 0;
    got = 0; cyc = 0;
    while (!got && cyc < 12) begin @(negedge clk); cyc++; got = a_ack | b_ack; end
    chk("contend second is A", {30'd0, a_ack, b_ack}, 2'b10);
    chk("contend A rdata", a_rdata, 16'h5AEF);
    a_req = 0;

    // Reset during ACCESS of a B read.
    b_req = 1; b_write = 0; b_addr = 9'h020;
    @(negedge clk);
    chk("pre-reset oe", ram_output_en, 1);
    reset = 0;
    #1;
    chk("midreset ram ctl", {30'd0, ram_write_rq, ram_output_en}, 0);
    chk("midreset ram addr", 32'(ram_addr), 0);
    chk("midreset acks", {30'd0, a_ack, b_ack}, 0);
    b_req = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("in reset acks %0d", k), {30'd0, a_ack, b_ack}, 0);
    end
    reset = 1;
    @(negedge clk);
    chk("post reset no ack", {30'd0, a_ack, b_ack}, 0);
    run_access(rd_a, "post reset A");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
